systolic_operand_feeder: RTL
============================

Name: systolic_operand_feeder

Overview:
- Upstream stage of the systolic array wrapper; produces its `en`/`last`/`a`/`b` inputs.
- Joins two independent valid/ready operand streams (A row-vectors, B column-vectors) into lock-step beats.
- Marks the final beat of a product with `last_o`.
- Holds off the next product until the array's drain window has elapsed, then reports completion.

Parameters:
- SIZE, 4, systolic array dimension; number of lanes per vector.
- DATA_W, 16, bits per lane element.
- K_MAX, 255, largest accepted reduction length.
- DRAIN_CYCLES, 2*SIZE+5, idle cycles after the last beat before `done_o`; covers the downstream 2*SIZE+4 drain plus this block's output register.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- start_i  in  1  begin a product; sampled only in IDLE
- k_len_i  in  $clog2(K_MAX+1)  number of beats for this product; sampled with start_i
- busy_o  out  1  high in FEED or DRAIN
- done_o  out  1  one-cycle pulse when the product completes
- a_valid_i  in  1  A beat available
- a_ready_o  out  1  A beat consumed this cycle
- a_data_i  in  SIZE*DATA_W  A vector; lane i at bits [i*DATA_W +: DATA_W]
- b_valid_i  in  1  B beat available
- b_ready_o  out  1  B beat consumed this cycle
- b_data_i  in  SIZE*DATA_W  B vector; same packing as A
- en_o  out  1  beat strobe to the array
- last_o  out  1  final beat of the product
- a_o  out  SIZE*DATA_W  registered A vector
- b_o  out  SIZE*DATA_W  registered B vector

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset values: state IDLE; beat counter, drain counter, busy_o, done_o, en_o, last_o, a_o, b_o, a_ready_o, b_ready_o all 0.
- Reset asserted mid-operation aborts the product:
  - no done_o is produced;
  - the next cycle after reset release is IDLE with all outputs 0.
- State IDLE:
  - start_i=1 with k_len_i>0: latch k_len_i, clear the beat counter, go to FEED.
  - start_i=1 with k_len_i=0: go to DRAIN directly; no beats are issued.
  - start_i with k_len_i>K_MAX: saturate k_len to K_MAX.
- State FEED:
  - fire = a_valid_i & b_valid_i.
  - a_ready_o = b_ready_o = FEED & fire (combinational). A beat is never consumed from one stream alone.
  - On fire, the next cycle drives:
    - en_o=1;
    - a_o=a_data_i and b_o=b_data_i (values from the fire cycle);
    - last_o=1 if this beat is number k_len-1, else 0.
  - Latency is exactly 1 cycle from fire to en_o.
  - No fire: next cycle en_o=0, last_o=0, a_o=b_o=0. Stall gaps are permitted; the array tolerates en gaps.
  - Beat counter increments on each fire.
  - The final fire moves the state to DRAIN with the drain counter loaded to DRAIN_CYCLES-1.
- State DRAIN:
  - readies held 0.
  - drain counter decrements once per cycle.
  - at 0: done_o=1 for exactly that cycle, then IDLE.
- start_i outside IDLE is ignored; k_len_i is not re-sampled.
- busy_o = (state != IDLE), registered with the state.
- Counter widths:
  - beat counter $clog2(K_MAX+1) bits, no wrap possible.
  - drain counter $clog2(DRAIN_CYCLES) bits.

Optional Feature:
- Macro: FEEDER_ZERO_PAD_EN.
- Defined:
  - when the latched k_len < SIZE, FEED continues after the last real beat;
  - it issues SIZE-k_len pad beats, one per cycle, with a_o=b_o=0 and en_o=1, without consuming input;
  - last_o is on the final pad beat, not the last real beat; DRAIN starts after it;
  - k_len=0 issues SIZE zero beats.
- Undefined: no padding; behaviour exactly as above; no pad logic or counters are synthesised.

Test Plan:
- SIZE=4, k_len=4, both streams valid every cycle with A beats 1..4 (all lanes) and B beats 10..40 -> en_o high for 4 consecutive cycles starting 1 cycle after the first fire; last_o only with the 4th beat (a_o lanes=4, b_o lanes=40); done_o exactly DRAIN_CYCLES=13 cycles after the last fire cycle; busy_o low the cycle after done_o.
- k_len=3, b_valid_i low on cycles 2-3 while a_valid_i high -> a_ready_o=b_ready_o=0 during the gap, no A beat lost, en_o shows a 2-cycle gap, exactly 3 en_o pulses, last_o on the 3rd.
- start_i pulsed again during FEED with k_len_i=7 -> ignored; product ends after the original k_len beats; a single done_o.
- rst_i asserted in the 2nd cycle of DRAIN -> no done_o, all outputs 0; a new start with k_len=2 then completes normally.
- start with k_len_i=0 -> zero en_o pulses, done_o 13 cycles later (macro undefined); with FEEDER_ZERO_PAD_EN, 4 zero beats with last_o on the 4th.
- FEEDER_ZERO_PAD_EN, k_len=2, A=5,6 -> en_o for 4 cycles, a_o = 5, 6, 0, 0; last_o only on the 4th; exactly 2 input handshakes.

Source files
------------

// File: rtl/systolic_operand_feeder_if.sv
// Operand streams in (A rows, B columns) and lock-step beats out to the systolic array.
interface systolic_operand_feeder_if #(
    parameter int SIZE   = 4,
    parameter int DATA_W = 16
);
    logic                   a_valid_i;
    logic                   a_ready_o;
    logic [SIZE*DATA_W-1:0] a_data_i;
    logic                   b_valid_i;
    logic                   b_ready_o;
    logic [SIZE*DATA_W-1:0] b_data_i;
    logic                   en_o;
    logic                   last_o;
    logic [SIZE*DATA_W-1:0] a_o;
    logic [SIZE*DATA_W-1:0] b_o;

    modport slave (
        input  a_valid_i, a_data_i, b_valid_i, b_data_i,
        output a_ready_o, b_ready_o, en_o, last_o, a_o, b_o
    );

    modport master (
        output a_valid_i, a_data_i, b_valid_i, b_data_i,
        input  a_ready_o, b_ready_o, en_o, last_o, a_o, b_o
    );
endinterface

// File: rtl/systolic_operand_feeder.sv
// Joins A/B operand streams into systolic beats, then waits out the array drain; FEEDER_ZERO_PAD_EN adds zero pad beats up to SIZE.
// One cycle from fire to en_o; both readies rise only when both streams are valid in FEED, else held low.
module systolic_operand_feeder #(
    parameter int SIZE         = 4,
    parameter int DATA_W       = 16,
    parameter int K_MAX        = 255,
    parameter int DRAIN_CYCLES = 2*SIZE+5
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic [$clog2(K_MAX+1)-1:0] k_len_i,
    output logic                       busy_o,
    output logic                       done_o,
    systolic_operand_feeder_if.slave   opd
);
    localparam int KW = $clog2(K_MAX+1);
    localparam int DW = $clog2(DRAIN_CYCLES);
    localparam int VW = SIZE*DATA_W;
    localparam logic [KW-1:0] K_MAX_K    = KW'(K_MAX);
    localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES-1);
`ifdef FEEDER_ZERO_PAD_EN
    localparam int PW = $clog2(SIZE+1);
    localparam logic [KW-1:0] SIZE_K = KW'(SIZE);
    localparam logic [PW-1:0] SIZE_P = PW'(SIZE);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN
`ifdef FEEDER_ZERO_PAD_EN
        , S_PAD
`endif
    } state_t;

    state_t          r_state,     w_state_nxt;
    logic [KW-1:0]   r_k_len,     w_k_len_nxt;
    logic [KW-1:0]   r_beat_cnt,  w_beat_nxt;
    logic [DW-1:0]   r_drain_cnt, w_drain_nxt;
    logic            r_en,        w_en_nxt;
    logic            r_last,      w_last_nxt;
    logic [VW-1:0]   r_a,         w_a_nxt;
    logic [VW-1:0]   r_b,         w_b_nxt;
`ifdef FEEDER_ZERO_PAD_EN
    logic [PW-1:0]   r_pad_cnt,   w_pad_nxt;
`endif

    logic            w_fire;
    logic            w_take;
    logic            w_final_beat;
    logic [KW-1:0]   w_k_sat;

    assign w_fire       = opd.a_valid_i & opd.b_valid_i;
    assign w_take       = (r_state == S_FEED) & w_fire;
    assign w_final_beat = (r_beat_cnt == (r_k_len - KW'(1)));
    assign w_k_sat      = (k_len_i > K_MAX_K) ? K_MAX_K : k_len_i;

    always_comb begin
        w_state_nxt = r_state;
        w_k_len_nxt = r_k_len;
        w_beat_nxt  = r_beat_cnt;
        w_drain_nxt = r_drain_cnt;
        w_en_nxt    = 1'b0;
        w_last_nxt  = 1'b0;
        w_a_nxt     = '0;
        w_b_nxt     = '0;
`ifdef FEEDER_ZERO_PAD_EN
        w_pad_nxt   = r_pad_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_k_len_nxt = w_k_sat;
                    w_beat_nxt  = '0;
                    if (w_k_sat == '0) begin
`ifdef FEEDER_ZERO_PAD_EN
                        w_state_nxt = S_PAD;
                        w_pad_nxt   = SIZE_P;
`else
                        w_state_nxt = S_DRAIN;
                        w_drain_nxt = DRAIN_INIT;
`endif
                    end else begin
                        w_state_nxt = S_FEED;
                    end
                end
            end
            S_FEED: begin
                if (w_take) begin
                    w_en_nxt   = 1'b1;
                    w_a_nxt    = opd.a_data_i;
                    w_b_nxt    = opd.b_data_i;
                    w_beat_nxt = r_beat_cnt + KW'(1);
                    if (w_final_beat) begin
`ifdef FEEDER_ZERO_PAD_EN
                        // Short products hand the last_o flag over to the final pad beat.
                        if (r_k_len < SIZE_K) begin
                            w_state_nxt = S_PAD;
                            w_pad_nxt   = SIZE_P - PW'(r_k_len);
                        end else begin
                            w_last_nxt  = 1'b1;
                            w_state_nxt = S_DRAIN;
                            w_drain_nxt = DRAIN_INIT;
                        end
`else
                        w_last_nxt  = 1'b1;
                        w_state_nxt = S_DRAIN;
                        w_drain_nxt = DRAIN_INIT;
`endif
                    end
                end
            end
`ifdef FEEDER_ZERO_PAD_EN
            S_PAD: begin
                w_en_nxt  = 1'b1;
                w_pad_nxt = r_pad_cnt - PW'(1);
                if (r_pad_cnt == PW'(1)) begin
                    w_last_nxt  = 1'b1;
                    w_state_nxt = S_DRAIN;
                    w_drain_nxt = DRAIN_INIT;
                end
            end
`endif
            S_DRAIN: begin
                if (r_drain_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_drain_nxt = r_drain_cnt - DW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_k_len     <= '0;
            r_beat_cnt  <= '0;
            r_drain_cnt <= '0;
            r_en        <= 1'b0;
            r_last      <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
`ifdef FEEDER_ZERO_PAD_EN
            r_pad_cnt   <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_k_len     <= w_k_len_nxt;
            r_beat_cnt  <= w_beat_nxt;
            r_drain_cnt <= w_drain_nxt;
            r_en        <= w_en_nxt;
            r_last      <= w_last_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
`ifdef FEEDER_ZERO_PAD_EN
            r_pad_cnt   <= w_pad_nxt;
`endif
        end
    end

    assign busy_o        = (r_state != S_IDLE);
    assign done_o        = (r_state == S_DRAIN) && (r_drain_cnt == '0);
    assign opd.a_ready_o = w_take;
    assign opd.b_ready_o = w_take;
    assign opd.en_o      = r_en;
    assign opd.last_o    = r_last;
    assign opd.a_o       = r_a;
    assign opd.b_o       = r_b;
endmodule
